// File: rtl/mem_access_unit.sv
// mem_access_unit
//
// Memory-stage load/store adapter. Turns the memory-stage address, store data
// and access controls into a single word-aligned transaction on a
// single-outstanding req/ack bus. Byte/half stores are lane-replicated with
// byte enables. Loads are lane-selected and sign/zero extended into readdataM.
// stallM holds the pipeline until the access retires.
//
// Build option: define MEM_ALIGN_CHECK_EN to reject misaligned half/word
// accesses without touching the bus (addr_exc pulse). When it is undefined,
// addr_exc is tied low and misaligned accesses drop the low address bits.
//
// Parameters:
//   TIMEOUT_CYCLES  bus-wait cycles before an access is aborted (0 = never)
//   CNT_W           width of the wait counter, must hold TIMEOUT_CYCLES
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   memreqM         memory-stage instruction is a load or store
//   memwriteM       1 = store, 0 = load
//   sizeM           00 byte, 01 half, 10/11 word
//   unsignedM       zero-extend loads
//   aluoutM         byte address
//   writedataM      right-aligned store data
//   readdataM       formatted load data, held until the next load retires
//   stallM          hold the pipeline
//   bus_err         one-cycle pulse when an access times out
//   addr_exc        one-cycle pulse on a rejected misaligned access
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata   bus request side
//   bus_ack/bus_rdata                          bus completion side
//
// FSM states:
//   state | meaning
//   IDLE  | no access in flight; captures a new access when memreqM is high
//   REQ   | bus_req asserted, waiting for bus_ack or the timeout
//   DONE  | access retired; pipeline released for one cycle

module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memreqM,
    input  logic        memwriteM,
    input  logic [1:0]  sizeM,
    input  logic        unsignedM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        bus_err,
    output logic        addr_exc,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST  = (TIMEOUT_CYCLES == 0) ? '0
                                             : CNT_W'(TIMEOUT_CYCLES - 1);

    stateT            state;
    stateT            stateNext;
    logic [CNT_W-1:0] waitCnt;
    logic             timeoutHit;
    logic             misaligned;

    logic             busWeQ;
    logic [31:0]      busAddrQ;
    logic [3:0]       busBeQ;
    logic [31:0]      busWdataQ;
    logic [1:0]       sizeQ;
    logic             unsQ;
    logic [1:0]       offQ;
    logic [31:0]      readdataQ;
    logic             busErrQ;

    logic [3:0]       laneBe;
    logic [31:0]      laneWdata;
    logic [7:0]       loadByte;
    logic [15:0]      loadHalf;
    logic [31:0]      loadFmt;

    // Misalignment only matters when the check is built in; otherwise the
    // low address bits are simply dropped by the word-aligned bus address.
`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        misaligned = 1'b0;
        case (sizeM)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = aluoutM[0];
            default: misaligned = |aluoutM[1:0];
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    assign timeoutHit = TIMEOUT_EN && (waitCnt == CNT_LAST);

    // Little-endian store lane mapping; loads always read the full word.
    always_comb begin
        laneBe    = 4'b1111;
        laneWdata = writedataM;
        if (memwriteM) begin
            case (sizeM)
                2'b00: begin
                    laneBe    = 4'b0001 << aluoutM[1:0];
                    laneWdata = {4{writedataM[7:0]}};
                end
                2'b01: begin
                    laneBe    = aluoutM[1] ? 4'b1100 : 4'b0011;
                    laneWdata = {2{writedataM[15:0]}};
                end
                default: begin
                    laneBe    = 4'b1111;
                    laneWdata = writedataM;
                end
            endcase
        end
    end

    // Load formatting uses the size/sign/offset captured at issue, since the
    // pipeline inputs are not guaranteed stable while the bus is busy.
    always_comb begin
        loadByte = 8'h00;
        case (offQ)
            2'd0: loadByte = bus_rdata[7:0];
            2'd1: loadByte = bus_rdata[15:8];
            2'd2: loadByte = bus_rdata[23:16];
            2'd3: loadByte = bus_rdata[31:24];
            default: loadByte = 8'h00;
        endcase
        loadHalf = offQ[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (sizeQ)
            2'b00:   loadFmt = {{24{~unsQ & loadByte[7]}}, loadByte};
            2'b01:   loadFmt = {{16{~unsQ & loadHalf[15]}}, loadHalf};
            default: loadFmt = bus_rdata;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // FSM: next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (memreqM) begin
                    stateNext = misaligned ? DONE : REQ;
                end
            end
            REQ: begin
                if (bus_ack || timeoutHit) begin
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // FSM: outputs. The IDLE stall is gated by rst so a reset that lands
    // while memreqM is still high releases the pipeline immediately.
    always_comb begin
        stallM  = 1'b0;
        bus_req = 1'b0;
        case (state)
            IDLE: stallM = memreqM & ~rst;
            REQ: begin
                stallM  = 1'b1;
                bus_req = 1'b1;
            end
            default: begin
                stallM  = 1'b0;
                bus_req = 1'b0;
            end
        endcase
    end

    // Access capture, wait counter and load result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busWeQ    <= 1'b0;
            busAddrQ  <= '0;
            busBeQ    <= '0;
            busWdataQ <= '0;
            sizeQ     <= '0;
            unsQ      <= 1'b0;
            offQ      <= '0;
            waitCnt   <= '0;
            readdataQ <= '0;
            busErrQ   <= 1'b0;
        end else begin
            busErrQ <= 1'b0;
            case (state)
                IDLE: begin
                    if (memreqM) begin
                        busWeQ    <= memwriteM;
                        busAddrQ  <= {aluoutM[31:2], 2'b00};
                        busBeQ    <= laneBe;
                        busWdataQ <= laneWdata;
                        sizeQ     <= sizeM;
                        unsQ      <= unsignedM;
                        offQ      <= aluoutM[1:0];
                        waitCnt   <= '0;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        if (!busWeQ) begin
                            readdataQ <= loadFmt;
                        end
                    end else if (timeoutHit) begin
                        busErrQ <= 1'b1;
                        if (!busWeQ) begin
                            readdataQ <= '0;
                        end
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic addrExcQ;

    // Set on the IDLE->DONE edge of a rejected access, so it lines up with DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addrExcQ <= 1'b0;
        end else begin
            addrExcQ <= (state == IDLE) && memreqM && misaligned;
        end
    end

    assign addr_exc = addrExcQ;
`else
    assign addr_exc = 1'b0;
`endif

    assign readdataM = readdataQ;
    assign bus_err   = busErrQ;
    assign bus_we    = busWeQ;
    assign bus_addr  = busAddrQ;
    assign bus_be    = busBeQ;
    assign bus_wdata = busWdataQ;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        memreqM;
    logic        memwriteM;
    logic [1:0]  sizeM;
    logic        unsignedM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    // default-parameter instance
    logic [31:0] readdataM, bus_addr, bus_wdata;
    logic        stallM, bus_err, addr_exc, bus_req, bus_we;
    logic [3:0]  bus_be;

    // short-timeout instance
    logic [31:0] readdataMT, busAddrT, busWdataT;
    logic        stallMT, busErrT, addrExcT, busReqT, busWeT;
    logic [3:0]  busBeT;

    mem_access_unit u_dut (
        .clk(clk), .rst(rst), .memreqM(memreqM), .memwriteM(memwriteM),
        .sizeM(sizeM), .unsignedM(unsignedM), .aluoutM(aluoutM),
        .writedataM(writedataM), .readdataM(readdataM), .stallM(stallM),
        .bus_err(bus_err), .addr_exc(addr_exc), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) u_dutTo (
        .clk(clk), .rst(rst), .memreqM(memreqM), .memwriteM(memwriteM),
        .sizeM(sizeM), .unsignedM(unsignedM), .aluoutM(aluoutM),
        .writedataM(writedataM), .readdataM(readdataMT), .stallM(stallMT),
        .bus_err(busErrT), .addr_exc(addrExcT), .bus_req(busReqT),
        .bus_we(busWeT), .bus_addr(busAddrT), .bus_be(busBeT),
        .bus_wdata(busWdataT), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // observed instance select
    logic        useT;
    logic [31:0] readS, addrS, wdataS;
    logic        stallS, errS, excS, reqS, weS;
    logic [3:0]  beS;
    assign readS  = useT ? readdataMT : readdataM;
    assign addrS  = useT ? busAddrT   : bus_addr;
    assign wdataS = useT ? busWdataT  : bus_wdata;
    assign stallS = useT ? stallMT    : stallM;
    assign errS   = useT ? busErrT    : bus_err;
    assign excS   = useT ? addrExcT   : addr_exc;
    assign reqS   = useT ? busReqT    : bus_req;
    assign weS    = useT ? busWeT     : bus_we;
    assign beS    = useT ? busBeT     : bus_be;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    int nChecks = 0;
    int nFail   = 0;

    // per-access observations
    int          stallCyc, reqCyc, errCnt, excCnt;
    bit          unstable;
    logic [31:0] sAddr, sWdata;
    logic [3:0]  sBe;
    logic        sWe;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          ackAt;
        int          expStall;
        logic [31:0] expRead;
        logic [31:0] expAddr;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
    } vecT;

    vecT vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference formatting, written from the lane rules with plain arithmetic.
    function automatic logic [31:0] refLoad(input logic [31:0] rd, input logic [1:0] sz,
                                             input logic uns, input int unsigned off);
        int unsigned v;
        if (sz == 2'b00) begin
            v = (rd >> (off * 8)) % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (rd >> ((off / 2) * 16)) % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [3:0] refBe(input logic we, input logic [1:0] sz, input int unsigned off);
        if (!we || sz >= 2'b10) return 4'hF;
        if (sz == 2'b00) return 4'(1 << off);
        return (off >= 2) ? 4'hC : 4'h3;
    endfunction

    function automatic logic [31:0] refWdata(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'b00) return (wd % 256) * 32'h0101_0101;
        if (sz == 2'b01) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic bit refMis(input logic [1:0] sz, input int unsigned off);
        if (sz == 2'b00) return 1'b0;
        if (sz == 2'b01) return (off % 2) != 0;
        return off != 0;
    endfunction

    // Presents one access like the pipeline would: inputs held while stallM
    // is high, ack returned on the ackAt-th request cycle (0 = never).
    task automatic runAccess(input logic we, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rd, input int ackAt);
        stallCyc = 0; reqCyc = 0; errCnt = 0; excCnt = 0; unstable = 0;
        memreqM = 1'b1; memwriteM = we; sizeM = sz; unsignedM = uns;
        aluoutM = addr; writedataM = wd; bus_rdata = rd; bus_ack = 1'b0;
        #1;
        while (stallS) begin
            stallCyc++;
            if (errS) errCnt++;
            if (excS) excCnt++;
            if (reqS) begin
                reqCyc++;
                if (reqCyc == 1) begin
                    sAddr = addrS; sBe = beS; sWe = weS; sWdata = wdataS;
                end else if (addrS !== sAddr || beS !== sBe || weS !== sWe || wdataS !== sWdata) begin
                    unstable = 1'b1;
                end
                bus_ack = (reqCyc == ackAt);
            end
            if (stallCyc >= 300) begin
                check("access cycle budget", stallCyc, 0);
                break;
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
            #1;
        end
        if (errS) errCnt++;
        if (excS) excCnt++;
        @(posedge clk); #1;
        memreqM = 1'b0;
        #1;
        if (errS) errCnt++;
        if (excS) excCnt++;
    endtask

    task automatic checkAcc(input string tag, input int expStall, input int expReq,
                            input logic [31:0] expRead, input logic [31:0] expAddr,
                            input logic [3:0] expBe, input logic expWe,
                            input logic [31:0] expWdata, input int expErr, input int expExc);
        check({tag, " stall cycles"}, stallCyc, expStall);
        check({tag, " req cycles"}, reqCyc, expReq);
        check({tag, " readdataM"}, readS, expRead);
        check({tag, " bus_err pulses"}, errCnt, expErr);
        check({tag, " addr_exc pulses"}, excCnt, expExc);
        if (expReq > 0) begin
            check({tag, " bus_addr"}, sAddr, expAddr);
            check({tag, " bus_be"}, sBe, expBe);
            check({tag, " bus_we"}, sWe, expWe);
            check({tag, " bus stable"}, unstable, 0);
            if (expWe) check({tag, " bus_wdata"}, sWdata, expWdata);
        end
    endtask

    task automatic pulseReset();
        @(posedge clk); #1;
        rst = 1'b1; memreqM = 1'b0; bus_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    logic [31:0] modelRead;
    logic        rWe, rUns;
    logic [1:0]  rSz;
    logic [31:0] rAddr, rWd, rRd;
    int          rAck;
    int unsigned rOff;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 2'b00, 1'b0, 32'h1003, 32'h0,        32'h80FF_1234, 1, 2, 32'hFFFF_FF80, 32'h1000, 4'hF, 32'h0};
        vecs[1] = '{1'b0, 2'b00, 1'b1, 32'h1003, 32'h0,        32'h80FF_1234, 1, 2, 32'h0000_0080, 32'h1000, 4'hF, 32'h0};
        vecs[2] = '{1'b1, 2'b01, 1'b0, 32'h2002, 32'h0000_BEEF, 32'h0,        1, 2, 32'h0000_0080, 32'h2000, 4'hC, 32'hBEEF_BEEF};
        vecs[3] = '{1'b0, 2'b10, 1'b0, 32'h4000, 32'h0,        32'hCAFE_0001, 5, 6, 32'hCAFE_0001, 32'h4000, 4'hF, 32'h0};
        vecs[4] = '{1'b0, 2'b01, 1'b0, 32'h0012, 32'h0,        32'h8001_7FFF, 2, 3, 32'hFFFF_8001, 32'h0010, 4'hF, 32'h0};
        vecs[5] = '{1'b0, 2'b01, 1'b1, 32'h0010, 32'h0,        32'h8001_7FFF, 1, 2, 32'h0000_7FFF, 32'h0010, 4'hF, 32'h0};
        vecs[6] = '{1'b1, 2'b00, 1'b0, 32'h0031, 32'h1234_5678, 32'h0,        3, 4, 32'h0000_7FFF, 32'h0030, 4'h2, 32'h7878_7878};
        vecs[7] = '{1'b1, 2'b10, 1'b0, 32'h0040, 32'hDEAD_BEEF, 32'h0,        1, 2, 32'h0000_7FFF, 32'h0040, 4'hF, 32'hDEAD_BEEF};
        vecs[8] = '{1'b0, 2'b00, 1'b0, 32'h0052, 32'h0,        32'h127F_3456, 4, 5, 32'h0000_007F, 32'h0050, 4'hF, 32'h0};
        vecs[9] = '{1'b0, 2'b11, 1'b0, 32'h0060, 32'h0,        32'h89AB_CDEF, 1, 2, 32'h89AB_CDEF, 32'h0060, 4'hF, 32'h0};

        useT = 1'b0;
        rst = 1'b1;
        memreqM = 1'b1; memwriteM = 1'b0; sizeM = 2'b10; unsignedM = 1'b0;
        aluoutM = 32'hFFFF_FFFF; writedataM = 32'hFFFF_FFFF; bus_ack = 1'b0; bus_rdata = 32'h0;

        // reset state
        #2;
        check("reset readdataM", readdataM, 32'h0);
        check("reset bus_req", bus_req, 0);
        check("reset bus_be", bus_be, 4'h0);
        check("reset bus_addr", bus_addr, 32'h0);
        check("reset bus_wdata", bus_wdata, 32'h0);
        check("reset stallM", stallM, 0);
        check("reset bus_err", bus_err, 0);
        check("reset addr_exc", addr_exc, 0);
        memreqM = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("idle stallM", stallM, 0);

        // directed vectors
        for (int i = 0; i < 10; i++) begin
            runAccess(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
                      vecs[i].rd, vecs[i].ackAt);
            checkAcc($sformatf("vec%0d", i), vecs[i].expStall, vecs[i].ackAt, vecs[i].expRead,
                     vecs[i].expAddr, vecs[i].expBe, vecs[i].we, vecs[i].expWdata, 0, 0);
        end

        // reset in the middle of a request
        memreqM = 1'b1; memwriteM = 1'b0; sizeM = 2'b10; unsignedM = 1'b0;
        aluoutM = 32'h5000; bus_rdata = 32'h2468_ACE0; bus_ack = 1'b0;
        @(posedge clk); #2;
        check("rstmid bus_req before", bus_req, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rstmid bus_req", bus_req, 0);
        check("rstmid stallM", stallM, 0);
        check("rstmid readdataM", readdataM, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; memreqM = 1'b0; bus_ack = 1'b1;
        #1;
        check("late ack stallM", stallM, 0);
        check("late ack bus_req", bus_req, 0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        #1;
        check("late ack bus_req after", bus_req, 0);
        check("late ack readdataM", readdataM, 32'h0);
        runAccess(1'b0, 2'b10, 1'b0, 32'h5004, 32'h0, 32'h1357_2468, 2);
        checkAcc("post-reset lw", 3, 2, 32'h1357_2468, 32'h5004, 4'hF, 1'b0, 32'h0, 0, 0);

        // randomized accesses against the reference model
        modelRead = 32'h1357_2468;
        for (int i = 0; i < 60; i++) begin
            rWe = 1'($urandom_range(0, 1)); rSz = 2'($urandom_range(0, 3));
            rUns = 1'($urandom_range(0, 1)); rAddr = $urandom; rWd = $urandom; rRd = $urandom;
            rAck = int'($urandom_range(1, 4));
            rOff = rAddr % 4;
            runAccess(rWe, rSz, rUns, rAddr, rWd, rRd, rAck);
            if (ALIGN_CHK && refMis(rSz, rOff)) begin
                checkAcc($sformatf("rand%0d", i), 1, 0, modelRead, 32'h0, 4'h0, rWe, 32'h0, 0, 1);
            end else begin
                if (!rWe) modelRead = refLoad(rRd, rSz, rUns, rOff);
                checkAcc($sformatf("rand%0d", i), 1 + rAck, rAck, modelRead, rAddr - rOff,
                         refBe(rWe, rSz, rOff), rWe, refWdata(rSz, rWd), 0, 0);
            end
        end

        // timeout on the short-timeout instance
        pulseReset();
        useT = 1'b1;
        runAccess(1'b0, 2'b10, 1'b0, 32'h6000, 32'h0, 32'h0F0F_0F0F, 1);
        checkAcc("to lw ok", 2, 1, 32'h0F0F_0F0F, 32'h6000, 4'hF, 1'b0, 32'h0, 0, 0);
        runAccess(1'b0, 2'b10, 1'b0, 32'h6004, 32'h0, 32'hFFFF_FFFF, 0);
        checkAcc("to abort", 5, 4, 32'h0, 32'h6004, 4'hF, 1'b0, 32'h0, 1, 0);
        check("to back idle bus_req", reqS, 0);
        check("to back idle stallM", stallS, 0);
        useT = 1'b0;
        pulseReset();

        // misaligned accesses
        runAccess(1'b0, 2'b10, 1'b0, 32'h3000, 32'h0, 32'h5566_7788, 1);
        checkAcc("lw aligned", 2, 1, 32'h5566_7788, 32'h3000, 4'hF, 1'b0, 32'h0, 0, 0);
        runAccess(1'b0, 2'b10, 1'b0, 32'h3001, 32'h0, 32'h1122_3344, 1);
`ifdef MEM_ALIGN_CHECK_EN
        checkAcc("lw misaligned", 1, 0, 32'h5566_7788, 32'h0, 4'h0, 1'b0, 32'h0, 0, 1);
`else
        checkAcc("lw misaligned", 2, 1, 32'h1122_3344, 32'h3000, 4'hF, 1'b0, 32'h0, 0, 0);
`endif
        runAccess(1'b1, 2'b01, 1'b0, 32'h3003, 32'h0000_ABCD, 32'h0, 1);
`ifdef MEM_ALIGN_CHECK_EN
        checkAcc("sh misaligned", 1, 0, 32'h5566_7788, 32'h0, 4'h0, 1'b1, 32'h0, 0, 1);
`else
        checkAcc("sh misaligned", 2, 1, 32'h1122_3344, 32'h3000, 4'hC, 1'b1, 32'hABCD_ABCD, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store adapter. Sits directly downstream of the pipelined datapath's execute/memory boundary.
- Consumes the memory-stage ALU address, store data and access controls. Drives a single-outstanding req/ack data bus.
- Returns formatted load data as readdataM and holds the pipeline with stallM until the access retires.
- Converts byte/half/word accesses into word-aligned bus transactions with byte enables and sign/zero extension.

Parameters:
- TIMEOUT_CYCLES, 255: bus-wait cycles before the access is aborted with bus_err. 0 disables the timeout.
- CNT_W, 8: width of the timeout counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- memreqM  in  1  memory-stage instruction performs a load or store
- memwriteM  in  1  1 = store, 0 = load
- sizeM  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- unsignedM  in  1  zero-extend loads (lbu/lhu)
- aluoutM  in  32  byte address
- writedataM  in  32  store data (right-aligned)
- readdataM  out  32  formatted load data
- stallM  out  1  hold all pipeline stages
- bus_err  out  1  one-cycle pulse: timeout abort
- addr_exc  out  1  one-cycle pulse: misaligned access (feature only)
- bus_req  out  1  bus request
- bus_we  out  1  bus write
- bus_addr  out  32  word address, {aluoutM[31:2],2'b00}
- bus_be  out  4  byte enables, lane k = bits 8k+7:8k
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  bus completion
- bus_rdata  in  32  bus read data, valid with bus_ack

Behaviour:
- FSM states: IDLE, REQ, DONE.
- Reset state: IDLE. All outputs and registers reset to 0, including readdataM, bus_req, bus_be and the counter.
- Asynchronous rst mid-access:
  - bus_req drops immediately.
  - A late bus_ack is ignored.
  - readdataM is cleared.
- IDLE, memreqM=0: stallM=0; stay in IDLE.
- IDLE, memreqM=1:
  - stallM=1 combinationally.
  - Register bus_we, bus_addr, bus_be, bus_wdata, plus size, sign and addr[1:0] for load formatting.
  - Clear the counter; next state REQ.
- REQ:
  - bus_req=1, stallM=1. All bus outputs held stable until bus_ack.
  - On bus_ack: a load captures formatted bus_rdata into readdataM; go to DONE.
  - Without bus_ack: the counter increments.
  - When TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 with no ack: drop the request, pulse bus_err, force readdataM=0 for a load, go to DONE.
- DONE:
  - stallM=0 for exactly one cycle so the pipeline advances; bus_req=0.
  - Next state IDLE. A memreqM seen in this cycle belongs to the retiring instruction and is ignored.
- Latency: minimum stall is 2 cycles (ack in the first REQ cycle). Each extra wait cycle adds 1.
- bus_ack outside REQ is ignored.
- Store lane mapping (little-endian):
  - Byte: be=1<<addr[1:0], wdata={4{wd[7:0]}}.
  - Half: be=addr[1]?1100:0011, wdata={2{wd[15:0]}}.
  - Word: be=1111, wdata=wd.
- Loads: bus_be=1111. Select the byte lane by addr[1:0] or the half by addr[1]. Sign-extend unless unsignedM.
- readdataM holds its last value across stores and idle cycles. It updates only when a load completes or times out.
- Misaligned accesses without the feature:
  - Half ignores addr[0]; word ignores addr[1:0].
  - The access proceeds normally; addr_exc is tied 0.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, never raises bus_req.
  - IDLE goes directly to DONE with stallM=1 for one cycle.
  - addr_exc pulses in the DONE cycle; readdataM is unchanged.
- Undefined: addr_exc is constant 0 and misaligned accesses are handled as in Behaviour.

Test Plan:
- lb addr=0x1003, bus_rdata=0x80FF_1234, ack on first REQ cycle -> readdataM=0xFFFF_FF80, stallM high exactly 2 cycles; lbu same -> 0x0000_0080.
- sh addr=0x2002, writedataM=0x0000_BEEF -> bus_addr=0x2000, bus_be=1100, bus_wdata=0xBEEF_BEEF, bus_we=1; readdataM unchanged.
- lw with ack delayed 5 cycles -> bus_req and bus_addr stable for 5 cycles, stallM high 6 cycles, readdataM=bus_rdata.
- TIMEOUT_CYCLES=4, no ack -> bus_req high 4 cycles, bus_err one-cycle pulse, readdataM=0, FSM back in IDLE.
- rst asserted during REQ -> bus_req=0 and stallM=0 immediately; subsequent bus_ack ignored; next lw completes normally.
- With MEM_ALIGN_CHECK_EN: lw addr=0x3001 -> no bus_req, addr_exc pulse, stallM high 1 cycle; without the macro -> bus_addr=0x3000, be=1111.
